// File: rtl/conv2d_relu_with_mem_pkg.sv
// Shared CNN package: convolution FSM state encoding, output-dimension helper
// and the memory bus protocol levels used by the shared-bus CNN stages.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_INPUT,
        LOAD_WEIGHT,
        MAC,
        WRITE_OUTPUT,
        NEXT,
        FINISHED
    } conv_state_t;

    // mem_w levels
    localparam logic BUS_READ    = 1'b0;
    localparam logic BUS_WRITE   = 1'b1;
    // mem_sel levels
    localparam logic BUS_SEL_ON  = 1'b1;
    localparam logic BUS_SEL_OFF = 1'b0;

    // Output side length of a valid-padding window of side k at stride s.
    function automatic int out_dim(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

endpackage

// File: rtl/conv2d_relu_with_mem_if.sv
// Control/handshake interface of the convolution stage.
//   start, input_addr, weight_addr, output_addr : requester -> conv
//   done, mem_w, mem_sel                         : conv -> requester / memory
// The tristate address/data nets are shared wires resolved at the top level,
// so they stay as inout ports of the conv module.
interface conv2d_relu_with_mem_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  done;
    logic                  mem_w;
    logic                  mem_sel;
    logic [ADDR_WIDTH-1:0] input_addr;
    logic [ADDR_WIDTH-1:0] weight_addr;
    logic [ADDR_WIDTH-1:0] output_addr;

    modport master (
        input  start, input_addr, weight_addr, output_addr,
        output done, mem_w, mem_sel
    );

    modport slave (
        output start, input_addr, weight_addr, output_addr,
        input  done, mem_w, mem_sel
    );
endinterface

// File: rtl/conv2d_relu_with_mem_mac_unit.sv
// Signed multiply-accumulate with synchronous clear, plus the output function
// ReLU -> arithmetic shift -> saturate to an unsigned DATA_WIDTH result.
//   clk, rst : clock, async active-high reset
//   clr      : acc <= 0 (wins over en)
//   en       : acc <= acc + a*b
//   a, b     : signed operands
//   result   : unsigned output of the current accumulator value
module conv_mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int SHIFT      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic        [DATA_WIDTH-1:0] result
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] MAX_OUT = ACC_WIDTH'((1 << DATA_WIDTH) - 1);

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] shifted;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc + prod_ext;
    end

    assign shifted = acc >>> SHIFT;

    always_comb begin
        result = shifted[DATA_WIDTH-1:0];
        if (acc[ACC_WIDTH-1])     result = '0;
        else if (shifted > MAX_OUT) result = '1;
    end
endmodule

// File: rtl/conv2d_relu_with_mem.sv
// Valid-padding, stride-1 KxK convolution with ReLU/shift/saturation over the
// shared memory bus. Loads the HEIGHTxWIDTH map and KxK kernel, then emits one
// OUT_HxOUT_W output word per pixel, row-major from output_addr.
//   clk, rst     : clock, async active-high reset
//   bus          : start/done handshake, base addresses, mem_w/mem_sel
//   address_bus  : driven while loading or writing, otherwise Z
//   data_bus     : driven only while writing, otherwise Z
module conv2d_relu_with_mem
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATABUS_WIDTH = 32,
    parameter int HEIGHT        = 6,
    parameter int WIDTH         = 6,
    parameter int K             = 3,
    parameter int ACC_WIDTH     = 20,
    parameter int SHIFT         = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    conv2d_relu_with_mem_if.master       bus,
    inout  wire  [ADDR_WIDTH-1:0]        address_bus,
    inout  wire  [DATABUS_WIDTH-1:0]     data_bus
);
    localparam int OUT_H = out_dim(HEIGHT, K, 1);
    localparam int OUT_W = out_dim(WIDTH, K, 1);
    localparam int CW    = $clog2((HEIGHT > WIDTH) ? HEIGHT : WIDTH);
    localparam int KW    = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0] H_LAST  = CW'(HEIGHT - 1);
    localparam logic [CW-1:0] W_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] OH_LAST = CW'(OUT_H - 1);
    localparam logic [CW-1:0] OW_LAST = CW'(OUT_W - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(K - 1);

    conv_state_t state, state_nx;

    logic                  done_r;
    logic [ADDR_WIDTH-1:0] addr;      // read pointer for both load phases
    logic [ADDR_WIDTH-1:0] wbase;     // weight base captured at start
    logic [ADDR_WIDTH-1:0] out_ptr;   // output_addr + y*OUT_W + x, kept incrementally
    logic [CW-1:0]         ld_r, ld_c;
    logic [KW-1:0]         ki, kj;    // kernel position, used for weight load and MAC
    logic [CW-1:0]         x, y;

    logic signed [DATA_WIDTH-1:0] in_mat [HEIGHT][WIDTH];
    logic signed [DATA_WIDTH-1:0] w_mat  [K][K];

    logic                  sel, wr, mac_en, mac_clr;
    logic                  in_last, k_last, px_last;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] rd_elem;
    logic                  unused_hi;

    assign rd_elem   = data_bus[DATA_WIDTH-1:0];
    assign unused_hi = ^data_bus[DATABUS_WIDTH-1:DATA_WIDTH];

    assign in_last = (ld_r == H_LAST) && (ld_c == W_LAST);
    assign k_last  = (ki == K_LAST) && (kj == K_LAST);
    assign px_last = (y == OH_LAST) && (x == OW_LAST);

    // Next state and bus control
    always_comb begin
        state_nx = state;
        sel      = BUS_SEL_OFF;
        wr       = BUS_READ;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        case (state)
            IDLE, FINISHED: if (bus.start) state_nx = LOAD_INPUT;
            LOAD_INPUT: begin
                sel = BUS_SEL_ON;
                if (in_last) state_nx = LOAD_WEIGHT;
            end
            LOAD_WEIGHT: begin
                sel = BUS_SEL_ON;
                if (k_last) begin
                    state_nx = MAC;
                    mac_clr  = 1'b1;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k_last) state_nx = WRITE_OUTPUT;
            end
            WRITE_OUTPUT: begin
                sel      = BUS_SEL_ON;
                wr       = BUS_WRITE;
                state_nx = NEXT;
            end
            NEXT: begin
                mac_clr  = 1'b1;
                state_nx = px_last ? FINISHED : MAC;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            done_r  <= 1'b0;
            addr    <= '0;
            wbase   <= '0;
            out_ptr <= '0;
            ld_r    <= '0;
            ld_c    <= '0;
            ki      <= '0;
            kj      <= '0;
            x       <= '0;
            y       <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, FINISHED: begin
                    // done holds in FINISHED until a new start is accepted
                    done_r <= (state == FINISHED) && !bus.start;
                    if (bus.start) begin
                        addr    <= bus.input_addr;
                        wbase   <= bus.weight_addr;
                        out_ptr <= bus.output_addr;
                        ld_r    <= '0;
                        ld_c    <= '0;
                        ki      <= '0;
                        kj      <= '0;
                        x       <= '0;
                        y       <= '0;
                    end
                end
                LOAD_INPUT: begin
                    addr <= in_last ? wbase : addr + 1'b1;
                    if (ld_c == W_LAST) begin
                        ld_c <= '0;
                        ld_r <= ld_r + 1'b1;
                    end else begin
                        ld_c <= ld_c + 1'b1;
                    end
                end
                LOAD_WEIGHT, MAC: begin
                    if (state == LOAD_WEIGHT) addr <= addr + 1'b1;
                    // kernel walk wraps to (0,0) so the next pixel starts clean
                    if (kj == K_LAST) begin
                        kj <= '0;
                        ki <= (ki == K_LAST) ? '0 : ki + 1'b1;
                    end else begin
                        kj <= kj + 1'b1;
                    end
                end
                NEXT: begin
                    out_ptr <= out_ptr + 1'b1;
                    if (x == OW_LAST) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Feature map and kernel storage (not reset)
    always_ff @(posedge clk) begin
        if (state == LOAD_INPUT)  in_mat[ld_r][ld_c] <= rd_elem;
        if (state == LOAD_WEIGHT) w_mat[ki][kj]      <= rd_elem;
    end

    conv_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT      (SHIFT)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (mac_clr),
        .en     (mac_en),
        .a      (in_mat[y + CW'(ki)][x + CW'(kj)]),
        .b      (w_mat[ki][kj]),
        .result (result)
    );

    assign bus.done    = done_r;
    assign bus.mem_sel = sel;
    assign bus.mem_w   = wr;

    assign address_bus = !sel ? 'z : (state == WRITE_OUTPUT) ? out_ptr : addr;
    assign data_bus    = (state == WRITE_OUTPUT)
                       ? {{(DATABUS_WIDTH - DATA_WIDTH){1'b0}}, result} : 'z;
endmodule
